// File: rtl/drc_burst_builder.sv
// drc_burst_builder: packs a stream of 16-byte words into burst descriptors bounded by length, 4 KB pages and an idle flush timeout
module drc_burst_builder #(
    parameter int p_max_beats = 16,
    parameter int p_timeout   = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [31:0]  i_base_addr,
    input  logic [131:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         data_wr,
    output logic [131:0] data_out,
    input  logic         data_full,
    output logic         burst_wr,
    output logic [39:0]  burst_out,
    input  logic         burst_full,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT} state_t;
    localparam logic [8:0]  max_beats_c = 9'(p_max_beats);
    localparam logic [31:0] tmo_last_c  = 32'(p_timeout - 1);
    state_t      state;
    logic [31:0] cur_addr, timer;
    logic [8:0]  beat_ctr, beat_nxt;
    logic [11:0] end_low;
    logic        last_seen, accept, close_burst, expire;
    // handshake, burst-close conditions and the outputs derived from state
    always_comb begin
        in_ready    = state == S_FILL && !data_full;
        accept      = in_valid && in_ready;
        beat_nxt    = beat_ctr + 9'd1;
        end_low     = cur_addr[11:0] + {beat_nxt[7:0], 4'd0};
        close_burst = beat_nxt == max_beats_c || end_low == 12'd0 || in_data[128];
        expire      = timer + 32'd1 >= tmo_last_c;
        data_wr     = accept;
        data_out    = in_data;
        burst_wr    = state == S_EMIT && !burst_full;
        burst_out   = {cur_addr, beat_ctr[7:0]};
        busy        = state != S_IDLE;
    end
    // transfer FSM: collect beats, close on length/page/last/timeout, then write the descriptor
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            beat_ctr  <= '0;
            timer     <= '0;
            last_seen <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (i_start) begin
                    cur_addr  <= i_base_addr & 32'hFFFF_FFF0;
                    beat_ctr  <= '0;
                    timer     <= '0;
                    last_seen <= 1'b0;
                    state     <= S_FILL;
                end
                S_FILL: if (accept) begin
                    beat_ctr  <= beat_nxt;
                    timer     <= '0;
                    last_seen <= in_data[128];
                    if (close_burst) state <= S_EMIT;
                end else if (beat_ctr != 9'd0) begin
                    timer <= timer + 32'd1;
                    if (expire) state <= S_EMIT;
                end
                S_EMIT: if (!burst_full) begin
                    cur_addr <= cur_addr + {19'd0, beat_ctr, 4'd0};
                    beat_ctr <= '0;
                    timer    <= '0;
                    done     <= last_seen;
                    state    <= last_seen ? S_IDLE : S_FILL;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
